// File: rtl/vscale_imm_gen_buf_pkg.sv
// rtl/vscale_imm_gen_buf_pkg.sv - shared types and helpers for the immediate decode buffer
//
// Purpose: occupancy encoding for the two-entry skid buffer and a helper that
// classifies immediate format codes as supported or not.
`include "vscale_ctrl_constants.vh"

package vscale_imm_gen_buf_pkg;

    localparam int IMM_TYPE_W = `IMM_TYPE_WIDTH;

    // Occupancy of the two-entry buffer; only three of four codes are legal.
    typedef enum logic [1:0] {
        CNT_0 = 2'd0,
        CNT_1 = 2'd1,
        CNT_2 = 2'd2
    } fifo_cnt_e;

    // Codes above IMM_Z have no defined format.
    function automatic logic imm_type_supported(input logic [IMM_TYPE_W-1:0] imm_type);
        return (imm_type <= `IMM_Z);
    endfunction

endpackage

// File: rtl/vscale_ctrl_constants.vh
// rtl/vscale_ctrl_constants.vh - immediate format select codes shared by the decode path
`ifndef VSCALE_CTRL_CONSTANTS_VH
`define VSCALE_CTRL_CONSTANTS_VH

`define IMM_TYPE_WIDTH 3
`define IMM_I 3'd0
`define IMM_S 3'd1
`define IMM_U 3'd2
`define IMM_J 3'd3
`define IMM_B 3'd4
`define IMM_Z 3'd5

`endif

// File: rtl/vscale_imm_decode.sv
// rtl/vscale_imm_decode.sv - combinational RISC-V immediate decoder
//
// Purpose: extracts the I/S/B/U/J/Z immediate from a raw instruction word.
// Ports:
//   inst      - 32-bit instruction word
//   imm_type  - format select
//   imm       - decoded immediate, XPR_LEN bits
//   bad_type  - format code was unsupported (decoded as I)
`include "vscale_ctrl_constants.vh"

module vscale_imm_decode
    import vscale_imm_gen_buf_pkg::*;
#(
    parameter int XPR_LEN = 32
) (
    input  logic [31:0]               inst,
    input  logic [`IMM_TYPE_WIDTH-1:0] imm_type,
    output logic [XPR_LEN-1:0]        imm,
    output logic                      bad_type
);

    logic sign;
    logic unused_opcode;

    assign sign          = inst[31];
    // Opcode bits carry no immediate payload in any format.
    assign unused_opcode = ^inst[6:0];

    always_comb begin
        imm      = '0;
        bad_type = 1'b0;
        case (imm_type)
            `IMM_S: imm = {{(XPR_LEN-11){sign}}, inst[30:25], inst[11:7]};
            `IMM_B: imm = {{(XPR_LEN-12){sign}}, inst[7], inst[30:25], inst[11:8], 1'b0};
            `IMM_U: imm = {{(XPR_LEN-31){sign}}, inst[30:12], 12'b0};
            `IMM_J: imm = {{(XPR_LEN-20){sign}}, inst[19:12], inst[20], inst[30:21], 1'b0};
            `IMM_Z: imm = {{(XPR_LEN-5){1'b0}}, inst[19:15]};
            default: begin
                // I format, also the fallback for unsupported codes.
                imm      = {{(XPR_LEN-11){sign}}, inst[30:20]};
                bad_type = ~imm_type_supported(imm_type);
            end
        endcase
    end

endmodule

// File: rtl/vscale_imm_gen_buf.sv
// rtl/vscale_imm_gen_buf.sv - immediate decoder feeding a two-entry skid buffer
//
// Purpose: decodes the immediate at the input and queues imm/tag/bad_type in a
// two-entry FIFO with valid/ready handshakes on both sides.
// Ports:
//   clk, reset                       - clock, synchronous active-high reset
//   flush                            - drop every buffered entry
//   in_valid/in_ready/in_inst/in_imm_type/in_tag - upstream entry
//   out_valid/out_ready/out_imm/out_tag/out_bad_type - head entry
`include "vscale_ctrl_constants.vh"

module vscale_imm_gen_buf
    import vscale_imm_gen_buf_pkg::*;
#(
    parameter int XPR_LEN = 32,
    parameter int TAG_W   = 5
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_inst,
    input  logic [`IMM_TYPE_WIDTH-1:0] in_imm_type,
    input  logic [TAG_W-1:0]           in_tag,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XPR_LEN-1:0]         out_imm,
    output logic [TAG_W-1:0]           out_tag,
    output logic                       out_bad_type
);

    logic [XPR_LEN-1:0] dec_imm;
    logic               dec_bad;

    fifo_cnt_e          count_q, count_d;
    logic [XPR_LEN-1:0] head_imm_q, head_imm_d;
    logic [TAG_W-1:0]   head_tag_q, head_tag_d;
    logic               head_bad_q, head_bad_d;
    logic [XPR_LEN-1:0] tail_imm_q, tail_imm_d;
    logic [TAG_W-1:0]   tail_tag_q, tail_tag_d;
    logic               tail_bad_q, tail_bad_d;

    logic push;
    logic pop;

    vscale_imm_decode #(
        .XPR_LEN (XPR_LEN)
    ) u_decode (
        .inst     (in_inst),
        .imm_type (in_imm_type),
        .imm      (dec_imm),
        .bad_type (dec_bad)
    );

    // A full buffer can still accept when the head leaves this same cycle.
    assign in_ready     = (count_q != CNT_2) | out_ready;
    assign out_valid    = (count_q != CNT_0);
    assign push         = in_valid & in_ready;
    assign pop          = out_valid & out_ready;

    assign out_imm      = head_imm_q;
    assign out_tag      = head_tag_q;
    assign out_bad_type = head_bad_q;

    always_comb begin
        count_d    = count_q;
        head_imm_d = head_imm_q;
        head_tag_d = head_tag_q;
        head_bad_d = head_bad_q;
        tail_imm_d = tail_imm_q;
        tail_tag_d = tail_tag_q;
        tail_bad_d = tail_bad_q;

        if (flush) begin
            count_d = CNT_0;
        end else begin
            case (count_q)
                CNT_0: begin
                    if (push) begin
                        head_imm_d = dec_imm;
                        head_tag_d = in_tag;
                        head_bad_d = dec_bad;
                        count_d    = CNT_1;
                    end
                end
                CNT_1: begin
                    if (push && !pop) begin
                        tail_imm_d = dec_imm;
                        tail_tag_d = in_tag;
                        tail_bad_d = dec_bad;
                        count_d    = CNT_2;
                    end else if (push && pop) begin
                        head_imm_d = dec_imm;
                        head_tag_d = in_tag;
                        head_bad_d = dec_bad;
                    end else if (pop) begin
                        count_d = CNT_0;
                    end
                end
                CNT_2: begin
                    if (pop) begin
                        head_imm_d = tail_imm_q;
                        head_tag_d = tail_tag_q;
                        head_bad_d = tail_bad_q;
                        if (push) begin
                            tail_imm_d = dec_imm;
                            tail_tag_d = in_tag;
                            tail_bad_d = dec_bad;
                        end else begin
                            count_d = CNT_1;
                        end
                    end
                end
                default: count_d = CNT_0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q    <= CNT_0;
            head_imm_q <= '0;
            head_tag_q <= '0;
            head_bad_q <= 1'b0;
            tail_imm_q <= '0;
            tail_tag_q <= '0;
            tail_bad_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            head_imm_q <= head_imm_d;
            head_tag_q <= head_tag_d;
            head_bad_q <= head_bad_d;
            tail_imm_q <= tail_imm_d;
            tail_tag_q <= tail_tag_d;
            tail_bad_q <= tail_bad_d;
        end
    end

endmodule

// File: doc/vscale_imm_gen_buf.md
VSCALE_IMM_GEN_BUF -- requirements
Module: vscale_imm_gen_buf

Interface
REQ-001 SHALL have parameter XPR_LEN, default 32: datapath width; legal values 32 and 64.
REQ-002 SHALL have parameter TAG_W, default 5: width of a sideband tag carried with each entry.
REQ-003 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port flush, input, 1: discards all buffered entries.
REQ-006 SHALL have port in_valid, input, 1: upstream entry offered.
REQ-007 SHALL have port in_ready, output, 1: buffer accepts an entry this cycle.
REQ-008 SHALL have port in_inst, input, 32: raw instruction word.
REQ-009 SHALL have port in_imm_type, input, `IMM_TYPE_WIDTH: immediate format select.
REQ-010 SHALL have port in_tag, input, TAG_W: opaque sideband, returned unchanged.
REQ-011 SHALL have port out_valid, output, 1: head entry available.
REQ-012 SHALL have port out_ready, input, 1: downstream consumes the head entry.
REQ-013 SHALL have port out_imm, output, XPR_LEN: decoded immediate of the head entry.
REQ-014 SHALL have port out_tag, output, TAG_W: tag of the head entry.
REQ-015 SHALL have port out_bad_type, output, 1: head entry had an unsupported imm_type.

Function
REQ-016 SHALL decode these formats: I, S, B, U, J and Z (CSR zimm = inst[19:15], zero-extended).
REQ-017 SHALL sign-extend I/S/B/U/J from inst[31] to XPR_LEN bits; B and J bit 0 = 0; U low 12 bits = 0.
REQ-018 SHALL treat imm_type codes 6 and 7 as unsupported: decode as I and set bad_type for that entry.
REQ-019 SHALL decode at input and store imm, tag and bad_type in a 2-entry FIFO (skid buffer).
REQ-020 SHALL hold occupancy count 0..2; transfer-in = in_valid & in_ready; transfer-out = out_valid & out_ready.
REQ-021 SHALL drive in_ready = (count < 2) | out_ready when count = 2; i.e. a full buffer accepts only while the head leaves in the same cycle.
REQ-022 SHALL drive out_valid = (count != 0); out_imm/out_tag/out_bad_type come from the head register, with no combinational path from in_* to out_*.
REQ-023 SHALL have latency 1: an entry accepted in cycle N with count 0 appears with out_valid in cycle N+1.
REQ-024 SHALL preserve order; simultaneous push and pop leaves count unchanged and advances the head.
REQ-025 SHALL keep the head entry's outputs stable while out_valid & ~out_ready.
REQ-026 SHALL let flush take priority: next count = 0 and any same-cycle input transfer is discarded; in_ready remains per REQ-021.
REQ-027 SHALL never overflow or underflow; a pop is ignored at count 0.

Reset
REQ-028 SHALL, on reset, set count = 0, out_valid = 0, out_imm = 0, out_tag = 0, out_bad_type = 0, in_ready = 1 in the following cycle.
REQ-029 SHALL give reset priority over flush and over any transfer in the same cycle; reset mid-stream drops all entries.

Structure
REQ-030 SHALL place IMM_TYPE_WIDTH = 3 and IMM_I=0, IMM_S=1, IMM_U=2, IMM_J=3, IMM_B=4, IMM_Z=5 in vscale_ctrl_constants.vh.
REQ-031 SHALL instantiate one combinational sub-module, vscale_imm_decode (parametrised by XPR_LEN), for decoding; the FIFO and control logic are local.

Verification
REQ-032 SHALL cover: I, inst 0xFFF00093 -> out_imm 0xFFFFFFFF (XPR_LEN 32) / 0xFFFFFFFFFFFFFFFF (64), bad_type 0, one-cycle latency.
REQ-033 SHALL cover: B, inst 0xFE000EE3 -> 0xFFFFFFFC; U, inst 0x800000B7 at XPR_LEN 64 -> 0xFFFFFFFF80000000; Z, inst 0x000FD073 -> 0x1F.
REQ-034 SHALL cover: out_ready=0 while 3 entries are pushed -> in_ready=0 after 2 accepts; release -> entries emerge in order with tags 1,2,3, none lost or duplicated.
REQ-035 SHALL cover: count=2, in_valid=1 and out_ready=1 held -> one accept and one pop every cycle, count steady at 2.
REQ-036 SHALL cover: flush with in_valid=1 at count=1 -> next cycle out_valid=0 and the input is not observed later.
REQ-037 SHALL cover: imm_type=7 with inst 0x00500093 -> out_imm 0x5 and out_bad_type=1; reset asserted at count=2 -> out_valid=0 and in_ready=1 in the next cycle.
